// File: rtl/ifclocks_pkg.sv
// Shared constants, configuration slot layout and sizing helpers for the IF clock divider block.
package ifclocks_pkg;

  localparam int MIN_DIV  = 2;
  localparam int CH_W     = 4;
  localparam int DIVW_MAX = 16;

  typedef struct packed {
    logic [DIVW_MAX-1:0] div;
    logic [DIVW_MAX-1:0] phase;
  } chan_cfg_t;

  function automatic int lock_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/ifclocks_divgen_if.sv
// Configuration request channel: one outstanding update per block, accepted on valid & ready.
interface ifclocks_divgen_if #(
  parameter int DIVW = 16
);
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [ifclocks_pkg::CH_W-1:0] cfg_ch;
  logic [DIVW-1:0]               cfg_div;
  logic [DIVW-1:0]               cfg_phase;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready);
endinterface

// File: rtl/ifclocks_divchan.sv
// One divided-clock channel: period counter, live and pending ratio/phase, apply at wrap, align re-phase.
module ifclocks_divchan
  import ifclocks_pkg::*;
#(
  parameter int              DIVW    = 16,
  parameter logic [DIVW-1:0] RST_DIV = DIVW'(2)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [DIVW-1:0] wr_div_i,
  input  logic [DIVW-1:0] wr_phase_i,
  input  logic            align_i,
  output logic            pend_o,
  output logic            pend_nxt_o,
  output logic            outclk_o,
  output logic            outstb_o
);

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] phase_q, phase_d;
  chan_cfg_t       slot_q, slot_d;
  logic            pend_q, pend_d;
  logic            outclk_q, outstb_q;
  logic            at_end;
  logic [DIVW:0]   high_len;

  function automatic logic [DIVW-1:0] clamp_div(input logic [DIVW-1:0] d);
    return (d < DIVW'(MIN_DIV)) ? DIVW'(MIN_DIV) : d;
  endfunction

  assign at_end   = (cnt_q == div_q - DIVW'(1));
  // Odd ratios get the extra cycle in the high half.
  assign high_len = ({1'b0, div_q} + (DIVW+1)'(1)) >> 1;

  always_comb begin
    cnt_d   = at_end ? '0 : cnt_q + DIVW'(1);
    div_d   = div_q;
    phase_d = phase_q;
    pend_d  = pend_q;
    slot_d  = slot_q;
    if (align_i) begin
      cnt_d = (phase_q < div_q) ? phase_q : '0;
    end else if (pend_q && at_end) begin
      cnt_d   = '0;
      div_d   = slot_q.div[DIVW-1:0];
      phase_d = slot_q.phase[DIVW-1:0];
      pend_d  = 1'b0;
    end
    if (wr_en_i) begin
      pend_d       = 1'b1;
      slot_d.div   = DIVW_MAX'(clamp_div(wr_div_i));
      slot_d.phase = DIVW_MAX'(wr_phase_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      div_q    <= RST_DIV;
      phase_q  <= '0;
      slot_q   <= '0;
      pend_q   <= 1'b0;
      outclk_q <= 1'b0;
      outstb_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      slot_q   <= slot_d;
      pend_q   <= pend_d;
      outclk_q <= ({1'b0, cnt_q} < high_len);
      outstb_q <= (cnt_q == '0);
    end
  end

  assign pend_o     = pend_q;
  assign pend_nxt_o = pend_d;
  assign outclk_o   = outclk_q;
  assign outstb_o   = outstb_q;

endmodule

// File: rtl/ifclocks_divgen.sv
// IF clock generator: NCLK programmable dividers off refclk with config decode, single-slot
// config acceptance and an output-settled lock indicator.
module ifclocks_divgen
  import ifclocks_pkg::*;
#(
  parameter int                   NCLK        = 3,
  parameter int                   DIVW        = 16,
  parameter logic [NCLK*DIVW-1:0] DEFAULT_DIV = {NCLK{DIVW'(2)}},
  parameter int                   LOCK_CYCLES = 1024
) (
  input  logic               refclk,
  input  logic               rst,
  ifclocks_divgen_if.slave   cfg,
  input  logic               align,
  output logic [NCLK-1:0]    outclk,
  output logic [NCLK-1:0]    outstb,
  output logic               locked
);

  localparam int             LKW      = lock_cnt_w(LOCK_CYCLES);
  localparam logic [LKW-1:0] LOCK_MAX = LKW'(LOCK_CYCLES);

  logic            hs;
  logic [NCLK-1:0] wr_en;
  logic [NCLK-1:0] pend;
  logic [NCLK-1:0] pend_nxt;
  logic            ready_q;
  logic [LKW-1:0]  lock_cnt_q, lock_cnt_d;
  logic            locked_q;

  assign hs            = cfg.cfg_valid & ready_q;
  assign cfg.cfg_ready = ready_q;

  // Out-of-range channel numbers match no slot, so the request is simply consumed.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NCLK; i++) begin
      wr_en[i] = hs && (cfg.cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NCLK; g++) begin : g_chan
    ifclocks_divchan #(
      .DIVW    (DIVW),
      .RST_DIV (DEFAULT_DIV[g*DIVW +: DIVW])
    ) u_chan (
      .clk_i      (refclk),
      .rst_i      (rst),
      .wr_en_i    (wr_en[g]),
      .wr_div_i   (cfg.cfg_div),
      .wr_phase_i (cfg.cfg_phase),
      .align_i    (align),
      .pend_o     (pend[g]),
      .pend_nxt_o (pend_nxt[g]),
      .outclk_o   (outclk[g]),
      .outstb_o   (outstb[g])
    );
  end

  always_comb begin
    if (hs || align || (|pend)) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q == LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q;
    end else begin
      lock_cnt_d = lock_cnt_q + LKW'(1);
    end
  end

  // Ready follows the next pending state so a second request can never slip in behind the first.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      ready_q    <= ~|pend_nxt;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= (lock_cnt_q == LOCK_MAX);
    end
  end

  assign locked = locked_q;

endmodule

// File: tb/tb_ifclocks_divgen.sv
// Bench for ifclocks_divgen: time-based period model checked every cycle, plus directed literal checks.
module tb_ifclocks_divgen;
  import ifclocks_pkg::*;

  localparam int NCLK = 3;
  localparam int DIVW = 16;
  localparam int LC   = 32;

  logic            refclk = 1'b0;
  logic            rst    = 1'b0;
  logic            align  = 1'b0;
  logic [NCLK-1:0] outclk;
  logic [NCLK-1:0] outstb;
  logic            locked;

  ifclocks_divgen_if #(.DIVW(DIVW)) cfg_if ();

  ifclocks_divgen #(
    .NCLK        (NCLK),
    .DIVW        (DIVW),
    .DEFAULT_DIV ({NCLK{16'd2}}),
    .LOCK_CYCLES (LC)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .cfg    (cfg_if),
    .align  (align),
    .outclk (outclk),
    .outstb (outstb),
    .locked (locked)
  );

  always #5 refclk = ~refclk;

  int n_chk  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: each channel's position is (edge index - base) mod div; apply/align just move base.
  int              mcyc;
  int              mdiv  [NCLK];
  int              mph   [NCLK];
  int              mbase [NCLK];
  int              mpdiv [NCLK];
  int              mpph  [NCLK];
  bit              mpend [NCLK];
  int              lkc;
  logic [NCLK-1:0] e_clk, e_stb;
  logic            e_rdy, e_lck;

  function automatic int mpos(input int i, input int k);
    int r;
    r = (k - mbase[i]) % mdiv[i];
    if (r < 0) r += mdiv[i];
    return r;
  endfunction

  task automatic model_reset();
    mcyc = 0;
    lkc  = 0;
    for (int i = 0; i < NCLK; i++) begin
      mdiv[i] = 2; mph[i] = 0; mbase[i] = 0; mpdiv[i] = 2; mpph[i] = 0; mpend[i] = 1'b0;
    end
    e_clk = '0; e_stb = '0; e_rdy = 1'b0; e_lck = 1'b0;
  endtask

  task automatic model_step();
    bit hs, anyp;
    int cur, nc, ch, d;
    hs   = cfg_if.cfg_valid && e_rdy;
    anyp = 1'b0;
    for (int i = 0; i < NCLK; i++) anyp |= mpend[i];
    mcyc++;
    for (int i = 0; i < NCLK; i++) begin
      cur      = mpos(i, mcyc - 1);
      e_clk[i] = (cur < (mdiv[i] + 1) / 2);
      e_stb[i] = (cur == 0);
      if (align) begin
        nc       = (mph[i] < mdiv[i]) ? mph[i] : 0;
        mbase[i] = mcyc - nc;
      end else if (mpend[i] && cur == mdiv[i] - 1) begin
        mdiv[i]  = mpdiv[i];
        mph[i]   = mpph[i];
        mpend[i] = 1'b0;
        mbase[i] = mcyc;
      end
    end
    ch = int'(cfg_if.cfg_ch);
    if (hs && ch < NCLK) begin
      d         = int'(cfg_if.cfg_div);
      mpend[ch] = 1'b1;
      mpdiv[ch] = (d < 2) ? 2 : d;
      mpph[ch]  = int'(cfg_if.cfg_phase);
    end
    e_lck = (lkc == LC);
    if (hs || align || anyp) lkc = 0;
    else if (lkc < LC)       lkc = lkc + 1;
    e_rdy = 1'b1;
    for (int i = 0; i < NCLK; i++) if (mpend[i]) e_rdy = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge refclk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge refclk);
      if (!done) begin
        chk("cyc_outclk", 32'(outclk), 32'(e_clk));
        chk("cyc_outstb", 32'(outstb), 32'(e_stb));
        chk("cyc_ready", 32'(cfg_if.cfg_ready), 32'(e_rdy));
        chk("cyc_locked", 32'(locked), 32'(e_lck));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic wait_ready(input string name, output int cyc);
    cyc = 0;
    while (!cfg_if.cfg_ready && cyc < 200) begin
      step(1);
      cyc++;
    end
    chk(name, 32'(cfg_if.cfg_ready), 32'd1);
  endtask

  task automatic do_cfg(input int ch, input int dv, input int ph);
    int c;
    wait_ready("cfg_wait", c);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CH_W'(ch);
    cfg_if.cfg_div   = DIVW'(dv);
    cfg_if.cfg_phase = DIVW'(ph);
    step(1);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_negedge_stb(input string name, input int ch);
    int c;
    c = 0;
    while (!outstb[ch] && c < 20) begin
      @(negedge refclk);
      c++;
    end
    chk(name, 32'(outstb[ch]), 32'd1);
  endtask

  initial begin
    int              c, e, t0, t0b, t1, t2;
    logic [4:0]      pat;
    logic [NCLK-1:0] prev;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_phase = '0;

    // Reset and default refclk/2 operation
    #1 rst = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    chk("t1_rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    rst = 1'b0;
    step(1);
    @(negedge refclk);
    chk("t1_edge1", 32'({outclk, outstb}), 32'b111111);
    step(1);
    @(negedge refclk);
    chk("t1_edge2", 32'({outclk, outstb}), 32'b000000);
    e = 2;
    while (!locked && e < LC + 10) begin
      step(1);
      e++;
    end
    chk("t1_lock_edge", 32'(e), 32'(LC + 1));

    // Ch1 to div 5
    step(1);
    do_cfg(1, 5, 0);
    wait_ready("t2_apply", c);
    pat = '0;
    for (int j = 0; j < 5; j++) begin
      step(1);
      @(negedge refclk);
      pat = {pat[3:0], outclk[1]};
    end
    chk("t2_ch1_pattern", 32'(pat), 32'b11100);
    chk("t2_locked_low", 32'(locked), 32'd0);
    step(LC + 4);
    chk("t2_locked_high", 32'(locked), 32'd1);

    // Clamping and out-of-range channel
    do_cfg(0, 0, 0);
    wait_ready("t3_apply0", c);
    do_cfg(2, 1, 0);
    wait_ready("t3_apply2", c);
    step(1);
    @(negedge refclk);
    prev = outstb;
    step(1);
    @(negedge refclk);
    chk("t3_ch0_alt", 32'(outstb[0] ^ prev[0]), 32'd1);
    chk("t3_ch2_alt", 32'(outstb[2] ^ prev[2]), 32'd1);
    do_cfg(7, 9, 3);
    chk("t3_ch7_ready", 32'(cfg_if.cfg_ready), 32'd1);
    step(3);

    // Align with phase offsets
    do_cfg(0, 8, 0);
    wait_ready("t4_apply0", c);
    do_cfg(1, 8, 4);
    wait_ready("t4_apply1", c);
    do_cfg(2, 8, 9);
    wait_ready("t4_apply2", c);
    step(2);
    align = 1'b1;
    step(1);
    align = 1'b0;
    t0 = -1; t0b = -1; t1 = -1; t2 = -1;
    for (int j = 1; j <= 10; j++) begin
      step(1);
      @(negedge refclk);
      if (outstb[0] && t0 < 0)       t0 = j;
      else if (outstb[0] && t0b < 0) t0b = j;
      if (outstb[1] && t1 < 0) t1 = j;
      if (outstb[2] && t2 < 0) t2 = j;
    end
    chk("t4_stb0_first", 32'(t0), 32'd1);
    chk("t4_stb1_after0", 32'(t1 - t0), 32'd4);
    chk("t4_stb1_leads0", 32'(t0b - t1), 32'd4);
    chk("t4_ch2_phase_oob", 32'(t2), 32'd1);

    // Align coinciding with ch2 apply boundary
    wait_negedge_stb("t5_sync", 2);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CH_W'(2);
    cfg_if.cfg_div   = DIVW'(3);
    cfg_if.cfg_phase = DIVW'(2);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    step(5);
    align = 1'b1;
    step(1);
    align = 1'b0;
    chk("t5_still_pending", 32'(cfg_if.cfg_ready), 32'd0);
    c = 0;
    while (!cfg_if.cfg_ready && c < 20) begin
      step(1);
      c++;
    end
    chk("t5_apply_delay", 32'(c), 32'd8);
    step(10);

    // Reset during a pending update with ch0 high
    wait_negedge_stb("t6_sync", 0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CH_W'(0);
    cfg_if.cfg_div   = DIVW'(6);
    cfg_if.cfg_phase = DIVW'(1);
    step(1);
    cfg_if.cfg_valid = 1'b0;
    step(1);
    chk("t6_clk0_high", 32'(outclk[0]), 32'd1);
    chk("t6_pending", 32'(cfg_if.cfg_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_outputs", 32'({outclk, outstb, locked, cfg_if.cfg_ready}), 32'd0);
    repeat (2) @(posedge refclk);
    #1 rst = 1'b0;
    step(1);
    @(negedge refclk);
    chk("t6_edge1", 32'({outclk, outstb}), 32'b111111);
    chk("t6_pending_lost", 32'(cfg_if.cfg_ready), 32'd1);
    step(1);
    @(negedge refclk);
    chk("t6_edge2", 32'({outclk, outstb}), 32'b000000);
    step(LC + 4);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
